apu_frame_sequencer: RTL and testbench

//  Frame sequencer for the APU ($4017). Counts CPU cycles and issues quarter-frame
//  (envelope/linear) and half-frame (length/sweep) tick pulses. The noise channel's

---
 rtl/apu_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// apu_frame_sequencer
//
// Purpose:
//   APU frame sequencer ($4017). Counts CPU cycles and emits quarter-frame
//   (envelope / linear counter) and half-frame (length / sweep) tick pulses,
//   handles $4017 writes (mode select, IRQ inhibit) with the delayed
//   sequencer restart, and drives the frame IRQ flag.
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   cpu_ce       in   1  one-clk enable marking a CPU cycle; all counting gated by it
//   wr_en        in   1  one-clk strobe: write to $4017
//   wr_data      in   8  [7]=mode (0=4-step, 1=5-step), [6]=IRQ inhibit
//   status_rd    in   1  one-clk strobe: $4015 read (clears frame IRQ)
//   quarter_tick out  1  one-clk pulse per quarter-frame event
//   half_tick    out  1  one-clk pulse per half-frame event
//   irq          out  1  frame IRQ flag (level)
//   mode         out  1  current sequencer mode
//   step         out  3  index of last step fired (0 = none since restart)
//
// Configuration:
//   APU_FRAME_IRQ_EN  when defined, the IRQ flag, inhibit bit and status_rd
//                     clear are built. When undefined, irq is tied to 0 and
//                     wr_data[6] / status_rd are ignored; tick timing is the
//                     same in both builds.
// ---------------------------------------------------------------------------
module apu_frame_sequencer #(
  parameter int CNT_W    = 16,
  parameter int STEP1    = 7457,
  parameter int STEP2    = 14913,
  parameter int STEP3    = 22371,
  parameter int STEP4    = 29829,
  parameter int STEP5    = 37281,
  parameter int WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarter_tick,
  output logic       half_tick,
  output logic       irq,
  output logic       mode,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] S1  = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2  = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3  = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4  = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5  = CNT_W'(STEP5);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [2:0]       DLY = 3'(WR_DELAY);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       pend;       // CPU cycles left until the write-triggered restart
  logic [2:0]       hit;        // step index matching cnt in the current mode, 0 = none
  logic             apply_rst;  // write-triggered restart happens on this edge
  logic             step_event;
  logic             last_hit;
  logic             half_hit;

  // Step decode. STEP4 is a step only in 4-step mode, STEP5 only in 5-step mode.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    hit = 3'd0;
    if (cnt == S1)                hit = 3'd1;
    else if (cnt == S2)           hit = 3'd2;
    else if (cnt == S3)           hit = 3'd3;
    else if (cnt == S4 && !mode)  hit = 3'd4;
    else if (cnt == S5 && mode)   hit = 3'd5;
  end

  // A write on the same edge restarts the delay, so it must block the restart
  // that the old pending count would otherwise have applied.
  assign apply_rst  = cpu_ce && !wr_en && (pend == 3'd1);
  // The restart wins over a coincident step match.
  assign step_event = cpu_ce && !apply_rst && (hit != 3'd0);
  assign last_hit   = (hit == 3'd4) || (hit == 3'd5);
  assign half_hit   = (hit == 3'd2) || last_hit;

  // Cycle counter, step index and registered tick pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      step         <= 3'd0;
      quarter_tick <= 1'b0;
      half_tick    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      quarter_tick <= 1'b0;
      half_tick    <= 1'b0;
      if (apply_rst) begin
        cnt          <= '0;
        step         <= 3'd0;
        // 5-step mode clocks both units immediately on restart.
        quarter_tick <= mode;
        half_tick    <= mode;
      end else if (step_event) begin
        quarter_tick <= 1'b1;
        half_tick    <= half_hit;
        step         <= hit;
        cnt          <= last_hit ? '0 : cnt + ONE;
      end else if (cpu_ce) begin
        cnt <= cnt + ONE;
      end
    end
  end

  // Pending-restart counter and mode register. Writes are taken on any clk,
  // independent of cpu_ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 3'd0;
      mode <= 1'b0;
    end else begin
      if (wr_en) begin
        pend <= DLY;
        mode <= wr_data[7];
      end else if (cpu_ce && pend != 3'd0) begin
        pend <= pend - 3'd1;
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit;
  logic irq_set;
  logic unused_inputs;

  // Only 4-step mode decodes hit==4, so this is the mode-0 STEP4 event.
  assign irq_set = step_event && (hit == 3'd4) && !inhibit;

  // Priority: inhibit write clears > IRQ set > status read clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_en) inhibit <= wr_data[6];
      if (wr_en && wr_data[6]) irq <= 1'b0;
      else if (irq_set)        irq <= 1'b1;
      else if (status_rd)      irq <= 1'b0;
    end
  end

  assign unused_inputs = ^wr_data[5:0];
`else
  logic unused_inputs;

  assign irq           = 1'b0;
  assign unused_inputs = ^{wr_data[6:0], status_rd};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apu_frame_sequencer
//
// Purpose:
//   Self-checking bench for apu_frame_sequencer at its default parameters.
//   A behavioural model tracks the CPU-cycle position within the frame, the
//   mode, inhibit, IRQ and pending-write delay using the step table below, and
//   every DUT output is compared against it one time unit after each rising
//   clock edge. Directed phases hit the boundary cases (IRQ set vs. status
//   read on one edge, double write restart landing on STEP2, 5-step forced
//   ticks, asynchronous reset mid-pending-write); cpu_ce dropouts and status
//   reads are randomized in between.
//
// Ports: none (top-level bench).
// Configuration: honours APU_FRAME_IRQ_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_apu_frame_sequencer;

  localparam int STEP_AT [5] = '{7457, 14913, 22371, 29829, 37281};
  localparam int WR_DELAY    = 3;
  localparam int BUDGET      = 60000;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cpu_ce;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       status_rd;
  logic       quarter_tick;
  logic       half_tick;
  logic       irq;
  logic       mode;
  logic [2:0] step;

  apu_frame_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ce       (cpu_ce),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .status_rd    (status_rd),
    .quarter_tick (quarter_tick),
    .half_tick    (half_tick),
    .irq          (irq),
    .mode         (mode),
    .step         (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state.
  int m_pos;    // CPU cycles since the frame started
  bit m_mode;
  bit m_inh;
  bit m_irq;
  int m_pend;   // CPU cycles until a write-triggered restart, 0 = none
  bit e_q;
  bit e_h;
  int e_step;

  // Which steps exist in each mode, which of them are half-frame steps, and
  // which one ends the frame.
  function automatic bit fires(bit m, int x);
    return m ? (x != 4) : (x != 5);
  endfunction

  function automatic int last_step(bit m);
    return m ? 5 : 4;
  endfunction

  function automatic bit halves(bit m, int x);
    return (x == 2) || (x == last_step(m));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_mode = 1'b0;
    m_inh  = 1'b0;
    m_irq  = 1'b0;
    m_pend = 0;
    e_q    = 1'b0;
    e_h    = 1'b0;
    e_step = 0;
  endtask

  task automatic model_edge(input bit ce, input bit wr, input logic [7:0] d, input bit rd);
    bit apply;
    bit set_irq;
    int hit;
    apply   = ce && !wr && (m_pend == 1);
    set_irq = 1'b0;
    hit     = 0;
    if (ce)
      for (int x = 1; x <= 5; x++)
        if (m_pos == STEP_AT[x-1] && fires(m_mode, x)) hit = x;
    e_q = 1'b0;
    e_h = 1'b0;
    if (apply) begin
      m_pos  = 0;
      e_step = 0;
      e_q    = m_mode;
      e_h    = m_mode;
    end else if (hit != 0) begin
      e_q     = 1'b1;
      e_h     = halves(m_mode, hit);
      e_step  = hit;
      m_pos   = (hit == last_step(m_mode)) ? 0 : m_pos + 1;
      set_irq = (hit == 4) && !m_inh;
    end else if (ce) begin
      m_pos++;
    end
    if (wr)                   m_pend = WR_DELAY;
    else if (ce && m_pend > 0) m_pend--;
    if (IRQ_EN) begin
      if (wr && d[6])  m_irq = 1'b0;
      else if (set_irq) m_irq = 1'b1;
      else if (rd)      m_irq = 1'b0;
      if (wr) m_inh = d[6];
    end
    if (wr) m_mode = d[7];
  endtask

  task automatic check_outputs();
    check("quarter_tick", quarter_tick, e_q);
    check("half_tick", half_tick, e_h);
    check("irq", irq, m_irq);
    check("mode", mode, m_mode);
    check("step", step, e_step[7:0]);
  endtask

  // One clk: drive inputs, advance the model on the edge, compare after it.
  task automatic cyc(input bit ce, input bit wr, input logic [7:0] d, input bit rd);
    cpu_ce    = ce;
    wr_en     = wr;
    wr_data   = d;
    status_rd = rd;
    @(posedge clk);
    model_edge(ce, wr, d, rd);
    #1;
    check_outputs();
    cpu_ce    = 1'b0;
    wr_en     = 1'b0;
    status_rd = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      model_reset();
      check_outputs();
    end
    rst = 1'b0;
  endtask

  // Run until the frame position reaches target, with random cpu_ce dropouts
  // (1 in drop_mod) and random status reads (1 in rd_mod); 0 disables either.
  task automatic run_to(input string tag, input int target, input int drop_mod, input int rd_mod);
    int guard;
    bit ce;
    bit rd;
    bit expired;
    guard = 0;
    while (m_pos != target && guard < BUDGET) begin
      ce = (drop_mod == 0) || ($urandom_range(drop_mod - 1) != 0);
      rd = (rd_mod != 0) && ($urandom_range(rd_mod - 1) == 0);
      cyc(ce, 1'b0, 8'h00, rd);
      guard++;
    end
    expired = (m_pos != target);
    check({"reach_", tag}, {7'd0, expired}, 8'd0);
  endtask

  initial begin
    int gap_at;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cpu_ce    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    status_rd = 1'b0;
    model_reset();

    // Reset state, then a short run and an asynchronous reset while a 5-step
    // write is still pending: everything returns to zero and no restart follows.
    reset_cycles(3);
    run_to("pre", int'($urandom_range(800, 300)), 8, 64);
    cyc(1'b1, 1'b1, 8'hC0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_mode", mode, 8'd0);
    check("async_rst_step", step, 8'd0);
    check("async_rst_irq", irq, 8'd0);
    check_outputs();
    reset_cycles(2);

    // 4-step frame from reset with a 100-clk cpu_ce hold mid-frame. The IRQ
    // set at STEP4 coincides with a status read: the set wins.
    gap_at = int'($urandom_range(11000, 9000));
    run_to("gap", gap_at, 64, 2048);
    repeat (100) cyc(1'b0, 1'b0, 8'h00, ($urandom_range(31) == 0));
    run_to("step4", STEP_AT[3], 64, 2048);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("step4_step", step, 8'd4);
    check("step4_half", half_tick, 8'd1);
    check("irq_set_wins", irq, {7'd0, IRQ_EN});
    repeat ($urandom_range(6, 2)) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("irq_rd_clear", irq, 8'd0);

    // Second 4-step frame: first quarter tick, then two writes two clks apart
    // whose single restart lands on STEP2, suppressing the STEP2 event.
    run_to("f2_step1", STEP_AT[0], 64, 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("f2_quarter", quarter_tick, 8'd1);
    check("f2_step1", step, 8'd1);
    run_to("f2_pre", STEP_AT[1] - 5, 64, 0);
    cyc(1'b1, 1'b1, 8'hC0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'hC0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("no_early_rst", step, 8'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("coincide_step", step, 8'd0);
    check("coincide_quarter", quarter_tick, 8'd1);
    check("coincide_half", half_tick, 8'd1);
    check("mode_5step", mode, 8'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("forced_pulse_ends", quarter_tick, 8'd0);

    // Full 5-step frame: nothing at STEP4, wrap event at STEP5, IRQ never set.
    run_to("m1_step4", STEP_AT[3], 64, 512);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("m1_no_step4", quarter_tick, 8'd0);
    check("m1_step_held", step, 8'd3);
    run_to("m1_step5", STEP_AT[4], 64, 512);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("m1_step5", step, 8'd5);
    check("m1_step5_quarter", quarter_tick, 8'd1);
    check("m1_step5_half", half_tick, 8'd1);
    check("m1_irq", irq, 8'd0);
    repeat (20) cyc(1'b1, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
